// File: rtl/voice_allocator.sv
// voice_allocator: parses MIDI note-on/note-off bytes, keeps a voice table and
// issues one keystate update (flag, status, voice, note, velocity) per event.
// Optional feature macro: CHANNEL_FILTER_EN (accept only messages on i_channel;
// undefined = omni mode, i_channel ignored).
module voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int UPDATE_GAP = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_byte_valid,
    input  logic [7:0] i_byte,
    input  logic [3:0] i_channel,
    output logic       o_SPI_flag,
    output logic       o_SPI_note_status,
    output logic [7:0] o_SPI_voice_index,
    output logic [6:0] o_note,
    output logic [6:0] o_velocity,
    output logic       o_overflow
);
    localparam int IW = (NUM_VOICES > 2) ? $clog2(NUM_VOICES) : 1;
    localparam int GW = (UPDATE_GAP > 1) ? $clog2(UPDATE_GAP + 1) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_VOICES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(UPDATE_GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_GAP} state_t;

    // parser state
    logic       r_run_valid;
    logic       r_run_on;
    logic [3:0] r_run_chan;
    logic       r_have_d1;
    logic [6:0] r_d1;

    // one-entry message register
    logic       r_msg_full;
    logic       r_msg_on;
    logic [6:0] r_msg_note;
    logic [6:0] r_msg_vel;
    logic       r_overflow;

    // allocator
    state_t                       r_state;
    logic                         r_work_on;
    logic [6:0]                   r_work_note;
    logic [6:0]                   r_work_vel;
    logic [IW-1:0]                r_scan_idx;
    logic                         r_match_found;
    logic [IW-1:0]                r_match_idx;
    logic                         r_free_found;
    logic [IW-1:0]                r_free_idx;
    logic [IW-1:0]                r_steal_ptr;
    logic [GW-1:0]                r_gap_cnt;
    logic [NUM_VOICES-1:0]        r_active;
    logic [NUM_VOICES-1:0][6:0]   r_vnote;

    // registered outputs
    logic       r_flag;
    logic       r_status;
    logic [7:0] r_vidx;
    logic [6:0] r_note;
    logic [6:0] r_vel;

    logic          w_done;
    logic          w_msg_on;
    logic          w_chan_ok;
    logic          w_accept;
    logic          w_take;
    logic [IW-1:0] w_pick;

    // second data byte of a note message completes it; velocity 0 means note-off
    assign w_done   = i_byte_valid && !i_byte[7] && r_run_valid && r_have_d1;
    assign w_msg_on = r_run_on && (i_byte[6:0] != 7'd0);

`ifdef CHANNEL_FILTER_EN
    assign w_chan_ok = (r_run_chan == i_channel);
`else
    assign w_chan_ok = 1'b1;
    logic w_unused;
    assign w_unused = ^{i_channel, r_run_chan};
`endif

    assign w_accept = w_done && w_chan_ok;
    // the message register is freed in the same cycle IDLE hands it to SCAN
    assign w_take   = (r_state == S_IDLE) && r_msg_full;
    // retrigger beats free voice beats steal
    assign w_pick   = r_match_found ? r_match_idx :
                      r_free_found  ? r_free_idx  : r_steal_ptr;

    // MIDI parser: running status tracking and data byte pairing
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_run_valid <= 1'b0;
            r_run_on    <= 1'b0;
            r_run_chan  <= 4'd0;
            r_have_d1   <= 1'b0;
            r_d1        <= 7'd0;
        end else if (i_byte_valid) begin
            if (i_byte[7]) begin
                // realtime bytes (F8-FF) leave the parser untouched
                if (i_byte[7:3] != 5'b11111) begin
                    r_have_d1 <= 1'b0;
                    if (i_byte[7:5] == 3'b100) begin
                        r_run_valid <= 1'b1;
                        r_run_on    <= i_byte[4];
                        r_run_chan  <= i_byte[3:0];
                    end else begin
                        r_run_valid <= 1'b0;
                    end
                end
            end else if (r_run_valid) begin
                if (r_have_d1) begin
                    r_have_d1 <= 1'b0;
                end else begin
                    r_d1      <= i_byte[6:0];
                    r_have_d1 <= 1'b1;
                end
            end
        end
    end

    // message register: fill when empty (or being freed), else drop and flag overflow
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_msg_full <= 1'b0;
            r_msg_on   <= 1'b0;
            r_msg_note <= 7'd0;
            r_msg_vel  <= 7'd0;
            r_overflow <= 1'b0;
        end else if (w_accept && (!r_msg_full || w_take)) begin
            r_msg_full <= 1'b1;
            r_msg_on   <= w_msg_on;
            r_msg_note <= r_d1;
            r_msg_vel  <= w_msg_on ? i_byte[6:0] : 7'd0;
        end else begin
            if (w_accept)
                r_overflow <= 1'b1;
            if (w_take)
                r_msg_full <= 1'b0;
        end
    end

    // allocator FSM, voice table and registered update outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_work_on     <= 1'b0;
            r_work_note   <= 7'd0;
            r_work_vel    <= 7'd0;
            r_scan_idx    <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_steal_ptr   <= '0;
            r_gap_cnt     <= '0;
            r_active      <= '0;
            r_vnote       <= '0;
            r_flag        <= 1'b0;
            r_status      <= 1'b0;
            r_vidx        <= 8'd0;
            r_note        <= 7'd0;
            r_vel         <= 7'd0;
        end else begin
            r_flag <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_msg_full) begin
                        r_work_on     <= r_msg_on;
                        r_work_note   <= r_msg_note;
                        r_work_vel    <= r_msg_vel;
                        r_scan_idx    <= '0;
                        r_match_found <= 1'b0;
                        r_free_found  <= 1'b0;
                        r_state       <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (!r_match_found && r_active[r_scan_idx] &&
                        (r_vnote[r_scan_idx] == r_work_note)) begin
                        r_match_found <= 1'b1;
                        r_match_idx   <= r_scan_idx;
                    end
                    if (!r_free_found && !r_active[r_scan_idx]) begin
                        r_free_found <= 1'b1;
                        r_free_idx   <= r_scan_idx;
                    end
                    if (r_scan_idx == LAST_IDX)
                        r_state <= S_EMIT;
                    else
                        r_scan_idx <= r_scan_idx + 1'b1;
                end
                S_EMIT: begin
                    r_gap_cnt <= '0;
                    r_state   <= S_GAP;
                    if (r_work_on) begin
                        r_active[w_pick] <= 1'b1;
                        r_vnote[w_pick]  <= r_work_note;
                        if (!r_match_found && !r_free_found)
                            r_steal_ptr <= (r_steal_ptr == LAST_IDX) ? '0 : r_steal_ptr + 1'b1;
                        r_flag   <= 1'b1;
                        r_status <= 1'b1;
                        r_vidx   <= 8'(w_pick);
                        r_note   <= r_work_note;
                        r_vel    <= r_work_vel;
                    end else if (r_match_found) begin
                        r_active[r_match_idx] <= 1'b0;
                        r_flag   <= 1'b1;
                        r_status <= 1'b0;
                        r_vidx   <= 8'(r_match_idx);
                        r_note   <= r_work_note;
                        r_vel    <= 7'd0;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST)
                        r_state <= S_IDLE;
                    else
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_SPI_flag        = r_flag;
    assign o_SPI_note_status = r_status;
    assign o_SPI_voice_index = r_vidx;
    assign o_note            = r_note;
    assign o_velocity        = r_vel;
    assign o_overflow        = r_overflow;

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Converts the incoming MIDI byte stream (delivered by the SPI byte receiver) into per-voice keystate updates for the ADSR block. Parses note-on/note-off messages, maintains a table of which voice plays which note, and selects a voice for each event. Drives the SPI update interface (flag, note status, voice index) that the ADSR buffers into its envelope RAM, plus note/velocity for the oscillator bank.

## Interface
- NUM_VOICES, 8: number of voices; legal range 2..256.
- UPDATE_GAP, 4: idle cycles enforced after each flag pulse, so the ADSR's one-deep update buffer drains.
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_byte_valid  in  1  one-cycle strobe: i_byte holds a new MIDI byte.
- i_byte  in  8  MIDI byte.
- i_channel  in  4  accepted MIDI channel (used only with CHANNEL_FILTER_EN).
- o_SPI_flag  out  1  one-cycle pulse: update valid.
- o_SPI_note_status  out  1  1 = key down, 0 = key up; valid with flag, held until the next flag.
- o_SPI_voice_index  out  8  target voice; valid with flag, held.
- o_note  out  7  note number of the event; valid with flag, held.
- o_velocity  out  7  velocity of the event (0 for note-off); valid with flag, held.
- o_overflow  out  1  sticky: a complete message was dropped. Cleared only by reset.

## Operation
- Parser: independent of the allocator FSM and runs every cycle.
  - Status byte 0x9n or 0x8n: latch it as the running status and expect 2 data bytes.
  - Other status byte in 0x80–0xEF or 0xF0–0xF7: clear the running status. Data bytes are then ignored until the next note status.
  - Realtime byte 0xF8–0xFF: ignored with no effect on parser state.
  - Data byte (bit7 = 0) with no valid running status: ignored.
  - After 2 data bytes the message is complete. The running status is kept, so further data pairs form new messages.
  - 0x9n with velocity 0 is treated as note-off.
- Message register: one entry.
  - A complete message is written into it when empty.
  - If it is full, the new message is dropped and o_overflow is set.
- Voice table: per voice, an active bit and a 7-bit note. Steal pointer steal_ptr starts at 0. All are cleared at reset.
- Allocator FSM, states IDLE → SCAN → EMIT → GAP → IDLE:
  - IDLE: if the message register is full, move it to working registers, free the register, and set scan index 0 → SCAN.
  - SCAN: examine one voice per cycle, index 0..NUM_VOICES-1. Record the lowest active voice whose note matches, and the lowest inactive voice. After the last index → EMIT.
  - EMIT, note-on:
    - Matching voice exists: use it (retrigger).
    - Else the lowest free voice exists: use it.
    - Else steal voice steal_ptr, then steal_ptr ← (steal_ptr+1) mod NUM_VOICES.
    - Set the chosen voice active with the new note. Pulse flag with status 1.
  - EMIT, note-off:
    - Matching voice exists: clear it to inactive and pulse flag with status 0.
    - No match: no flag, no table change.
  - GAP: count UPDATE_GAP cycles, then → IDLE. GAP is entered after every EMIT, including one with no flag.
- Reset mid-operation: all state, the table, the parser and the message register clear immediately. Any pending event is lost and no flag is emitted.

## Timing
- Reset values: o_SPI_flag 0, o_SPI_note_status 0, o_SPI_voice_index 0, o_note 0, o_velocity 0, o_overflow 0. FSM resets to IDLE.
- Final data byte accepted at edge N: the message register is full after N.
- If the FSM is in IDLE: IDLE at N+1, SCAN during N+2..N+1+NUM_VOICES, EMIT (flag high) at N+2+NUM_VOICES. With NUM_VOICES = 8 the flag is at N+10.
- Minimum spacing between flags: NUM_VOICES+2+UPDATE_GAP cycles (14 at the defaults).
- The message register is freed on the IDLE→SCAN transition. A message completing in that same cycle is accepted, not dropped.
- Byte strobes may arrive on consecutive cycles.

## Configuration
- CHANNEL_FILTER_EN defined: note messages whose channel nibble ≠ i_channel are parsed but discarded at completion. They do not set o_overflow.
- CHANNEL_FILTER_EN undefined: omni mode. All channels are accepted and i_channel is ignored.

## Test plan
- Reset, then bytes 0x90,0x3C,0x64 → one flag 10 cycles after the last byte: status 1, voice 0, note 0x3C, velocity 0x64.
- Continue with running status 0x40,0x50 then 0x3C,0x00 → note-on on voice 1 (note 0x40), then note-off on voice 0 (note 0x3C, velocity 0). Flags are ≥14 cycles apart.
- 9 distinct note-ons with NUM_VOICES = 8 → voices 0..7, then the 9th steals voice 0. A 10th distinct note-on steals voice 1.
- 0x80,0x30,0x10 with no active note 0x30 → no flag; the FSM returns to IDLE after the gap.
- 0xF8 inserted between the data bytes of a note-on → the message parses normally. Three messages back-to-back at one byte per cycle → the third is dropped and o_overflow = 1.
- With CHANNEL_FILTER_EN and i_channel = 2: 0x91,… produces no flag and 0x92,… produces a flag. Assert reset during SCAN → all outputs return to 0 and no flag is emitted.
